id_ex_stage: RTL and testbench

- Single-entry ID/EX pipeline stage that sits directly upstream of the ALU.
- Holds one decoded instruction and resolves data forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and drives the ALU's SrcA, SrcB and Operation, plus EX-stage control, under a valid/ready handshake.
- Consumer is the ALU plus the EX/MEM register.

---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/forward_mux.sv | 43 ++++
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared ALU opcodes, ID/EX stage state and held-instruction bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 4;
    localparam int REG_AW   = 5;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_NE  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] ALU_LT  = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_GE  = 4'b1011;
    localparam logic [ALU_OP_W-1:0] ALU_LTU = 4'b1100;
    localparam logic [ALU_OP_W-1:0] ALU_GEU = 4'b1101;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b1110;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_e;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic [REG_AW-1:0]   rs1;
        logic [REG_AW-1:0]   rs2;
        logic [REG_AW-1:0]   rd;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
    } id_ex_bundle_t;

endpackage

`default_nettype wire

// File: rtl/forward_mux.sv
// ============================================================================
// Module : forward_mux
// Brief  : Priority operand select: EX/MEM, then MEM/WB, then held value.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module forward_mux #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_rs,
    input  logic [DATA_WIDTH-1:0]     i_held_data,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_mem_rd,
    input  logic                      i_ex_mem_reg_write,
    input  logic [DATA_WIDTH-1:0]     i_ex_mem_result,
    input  logic [REG_ADDR_WIDTH-1:0] i_mem_wb_rd,
    input  logic                      i_mem_wb_reg_write,
    input  logic [DATA_WIDTH-1:0]     i_mem_wb_result,
    output logic                      o_mem_wb_hit,
    output logic [DATA_WIDTH-1:0]     o_data
);

    logic w_rs_nonzero;
    logic w_ex_mem_hit;

    // x0 is hard-wired to zero, so a write to it is never a real producer.
    assign w_rs_nonzero = (i_rs != '0);
    assign w_ex_mem_hit = i_ex_mem_reg_write & (i_ex_mem_rd == i_rs) & w_rs_nonzero;
    assign o_mem_wb_hit = i_mem_wb_reg_write & (i_mem_wb_rd == i_rs) & w_rs_nonzero;

    always_comb begin
        o_data = i_held_data;
        if (w_ex_mem_hit) begin
            o_data = i_ex_mem_result;
        end else if (o_mem_wb_hit) begin
            o_data = i_mem_wb_result;
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module : id_ex_stage
// Brief  : Single-entry ID/EX register with forwarding and load-use stall.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH     = XLEN,
    parameter int OPCODE_LENGTH  = ALU_OP_W,
    parameter int REG_ADDR_WIDTH = REG_AW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
    input  logic                      id_alu_src,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      id_branch,
    input  logic [REG_ADDR_WIDTH-1:0] ex_mem_rd,
    input  logic                      ex_mem_reg_write,
    input  logic                      ex_mem_mem_read,
    input  logic [DATA_WIDTH-1:0]     ex_mem_result,
    input  logic [REG_ADDR_WIDTH-1:0] mem_wb_rd,
    input  logic                      mem_wb_reg_write,
    input  logic [DATA_WIDTH-1:0]     mem_wb_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [DATA_WIDTH-1:0]     ex_pc,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_branch
);

    // The held bundle is sized by the package constants; parameters must match them.
    stage_state_e  r_state;
    id_ex_bundle_t r_held;
    id_ex_bundle_t w_incoming;

    logic w_accept;
    logic w_issue;
    logic w_hazard;
    logic w_rs1_wb_hit;
    logic w_rs2_wb_hit;
    logic w_rs2_used;

    assign w_incoming = '{
        pc:        id_pc,
        rs1_data:  id_rs1_data,
        rs2_data:  id_rs2_data,
        imm:       id_imm,
        rs1:       id_rs1,
        rs2:       id_rs2,
        rd:        id_rd,
        alu_op:    id_alu_op,
        alu_src:   id_alu_src,
        reg_write: id_reg_write,
        mem_read:  id_mem_read,
        mem_write: id_mem_write,
        branch:    id_branch
    };

    // rs2 is a real source for register-register ops and for store data.
    assign w_rs2_used = ~r_held.alu_src | r_held.mem_write;
    assign w_hazard   = ex_mem_mem_read & ex_mem_reg_write & (ex_mem_rd != '0) &
                        ((ex_mem_rd == r_held.rs1) |
                         ((ex_mem_rd == r_held.rs2) & w_rs2_used));

    assign out_valid = (r_state == FULL) & ~w_hazard;
    assign w_issue   = out_valid & out_ready;
    assign in_ready  = reset & ((r_state == EMPTY) | w_issue);
    assign w_accept  = in_valid & in_ready & ~flush;

    forward_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .i_rs               (r_held.rs1),
        .i_held_data        (r_held.rs1_data),
        .i_ex_mem_rd        (ex_mem_rd),
        .i_ex_mem_reg_write (ex_mem_reg_write),
        .i_ex_mem_result    (ex_mem_result),
        .i_mem_wb_rd        (mem_wb_rd),
        .i_mem_wb_reg_write (mem_wb_reg_write),
        .i_mem_wb_result    (mem_wb_result),
        .o_mem_wb_hit       (w_rs1_wb_hit),
        .o_data             (SrcA)
    );

    forward_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .i_rs               (r_held.rs2),
        .i_held_data        (r_held.rs2_data),
        .i_ex_mem_rd        (ex_mem_rd),
        .i_ex_mem_reg_write (ex_mem_reg_write),
        .i_ex_mem_result    (ex_mem_result),
        .i_mem_wb_rd        (mem_wb_rd),
        .i_mem_wb_reg_write (mem_wb_reg_write),
        .i_mem_wb_result    (mem_wb_result),
        .o_mem_wb_hit       (w_rs2_wb_hit),
        .o_data             (ex_store_data)
    );

    assign SrcB = r_held.alu_src ? r_held.imm : ex_store_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= EMPTY;
            r_held        <= '0;
            r_held.alu_op <= ALU_ADD;
        end else if (flush) begin
            r_state          <= EMPTY;
            r_held.reg_write <= 1'b0;
            r_held.mem_read  <= 1'b0;
            r_held.mem_write <= 1'b0;
            r_held.branch    <= 1'b0;
        end else if (w_accept) begin
            r_state <= FULL;
            r_held  <= w_incoming;
        end else if (w_issue) begin
            r_state          <= EMPTY;
            r_held.reg_write <= 1'b0;
            r_held.mem_read  <= 1'b0;
            r_held.mem_write <= 1'b0;
            r_held.branch    <= 1'b0;
        end else if (r_state == FULL) begin
            // Capture retiring results so a stalled operand outlives its producer.
            if (w_rs1_wb_hit) begin
                r_held.rs1_data <= mem_wb_result;
            end
            if (w_rs2_wb_hit) begin
                r_held.rs2_data <= mem_wb_result;
            end
        end
    end

    assign Operation    = r_held.alu_op;
    assign ex_pc        = r_held.pc;
    assign ex_rd        = r_held.rd;
    assign ex_reg_write = r_held.reg_write;
    assign ex_mem_read  = r_held.mem_read;
    assign ex_mem_write = r_held.mem_write;
    assign ex_branch    = r_held.branch;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module : tb_id_ex_stage
// Brief  : Directed vector and sequence bench for id_ex_stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_reg_write, ex_mem_mem_read;
    logic [31:0] ex_mem_result;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_reg_write;
    logic [31:0] mem_wb_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA, SrcB, ex_store_data, ex_pc;
    logic [3:0]  Operation;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .id_pc            (id_pc),
        .id_rs1_data      (id_rs1_data),
        .id_rs2_data      (id_rs2_data),
        .id_imm           (id_imm),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_rd            (id_rd),
        .id_alu_op        (id_alu_op),
        .id_alu_src       (id_alu_src),
        .id_reg_write     (id_reg_write),
        .id_mem_read      (id_mem_read),
        .id_mem_write     (id_mem_write),
        .id_branch        (id_branch),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .ex_mem_mem_read  (ex_mem_mem_read),
        .ex_mem_result    (ex_mem_result),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .mem_wb_result    (mem_wb_result),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .SrcA             (SrcA),
        .SrcB             (SrcB),
        .Operation        (Operation),
        .ex_store_data    (ex_store_data),
        .ex_pc            (ex_pc),
        .ex_rd            (ex_rd),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_branch        (ex_branch)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] d1, d2, imm;
        logic        alu_src, mw;
        logic [4:0]  exrd;
        logic        exrw, exmr;
        logic [31:0] exres;
        logic [4:0]  wbrd;
        logic        wbrw;
        logic [31:0] wbres;
        logic [31:0] ea, eb, es;
        logic        ev;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fwd_idle();
        ex_mem_rd = '0; ex_mem_reg_write = 1'b0; ex_mem_mem_read = 1'b0; ex_mem_result = '0;
        mem_wb_rd = '0; mem_wb_reg_write = 1'b0; mem_wb_result = '0;
    endtask

    task automatic load(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [3:0] op, input logic alu_src,
                        input logic rw, input logic mr, input logic mw, input logic br);
        id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_op = op;
        id_alu_src = alu_src; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw; id_branch = br;
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1, 2, 5, 7, 16, 0, 0, 1, 1, 0, 100, 1, 1, 50, 100,   7,   7, 1};
        vecs[1] = '{0, 2, 5, 7, 16, 0, 0, 0, 1, 0, 100, 0, 1, 50,   5,   7,   7, 1};
        vecs[2] = '{1, 2, 5, 7, 16, 0, 0, 1, 0, 0, 100, 1, 1, 50,  50,   7,   7, 1};
        vecs[3] = '{1, 2, 5, 7, 16, 0, 0, 2, 1, 0, 100, 3, 1, 50,   5, 100, 100, 1};
        vecs[4] = '{1, 2, 5, 7, 16, 1, 0, 3, 1, 0, 100, 2, 1, 50,   5,  16,  50, 1};
        vecs[5] = '{1, 2, 5, 7, 16, 0, 0, 1, 1, 1, 100, 0, 0, 50, 100,   7,   7, 0};
        vecs[6] = '{1, 2, 5, 7, 16, 1, 0, 2, 1, 1, 100, 0, 0, 50,   5,  16, 100, 1};
        vecs[7] = '{1, 2, 5, 7, 16, 1, 1, 2, 1, 1, 100, 0, 0, 50,   5,  16, 100, 0};
        vecs[8] = '{1, 2, 5, 7, 16, 0, 0, 1, 0, 1, 100, 0, 0, 50,   5,   7,   7, 1};
        vecs[9] = '{0, 2, 5, 7, 16, 0, 0, 0, 1, 1, 100, 0, 0, 50,   5,   7,   7, 1};

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_op = '0;
        id_alu_src = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_mem_write = 1'b0; id_branch = 1'b0;
        fwd_idle();
        step(); step();
        reset = 1'b1;
        #2;
        chk("post_reset_in_ready", in_ready, 1);
        chk("post_reset_op", Operation, 4'b0101);
        step();

        // Reset asserted while FULL and valid
        load(32'h40, 1, 2, 3, 5, 7, 0, 4'b0011, 0, 1, 0, 0, 0);
        #2;
        chk("t1_valid_before", out_valid, 1);
        chk("t1_op_before", Operation, 4'b0011);
        reset = 1'b0;
        #1;
        chk("t1_rst_valid", out_valid, 0);
        chk("t1_rst_in_ready", in_ready, 0);
        chk("t1_rst_op", Operation, 4'b0101);
        chk("t1_rst_reg_write", ex_reg_write, 0);
        step();
        reset = 1'b1;
        #2;
        chk("t1_release_in_ready", in_ready, 1);
        chk("t1_release_valid", out_valid, 0);
        step();

        // Forwarding / hazard vector table
        for (int i = 0; i < 10; i++) begin
            load(32'h1000 + i, vecs[i].rs1, vecs[i].rs2, 3, vecs[i].d1, vecs[i].d2,
                 vecs[i].imm, 4'b0101, vecs[i].alu_src, 1, 0, vecs[i].mw, 0);
            ex_mem_rd = vecs[i].exrd; ex_mem_reg_write = vecs[i].exrw;
            ex_mem_mem_read = vecs[i].exmr; ex_mem_result = vecs[i].exres;
            mem_wb_rd = vecs[i].wbrd; mem_wb_reg_write = vecs[i].wbrw;
            mem_wb_result = vecs[i].wbres;
            #2;
            chk($sformatf("v%0d_srca", i), SrcA, vecs[i].ea);
            chk($sformatf("v%0d_srcb", i), SrcB, vecs[i].eb);
            chk($sformatf("v%0d_store", i), ex_store_data, vecs[i].es);
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].ev);
            fwd_idle();
            flush = 1'b1;
            step();
            flush = 1'b0;
        end

        // Load-use stall then MEM/WB delivery
        load(32'h80, 4, 5, 6, 1, 2, 8, 4'b0101, 1, 1, 0, 0, 0);
        ex_mem_mem_read = 1'b1; ex_mem_reg_write = 1'b1; ex_mem_rd = 4; ex_mem_result = 32'hBAD;
        out_ready = 1'b1;
        #2;
        chk("t3_stall_valid", out_valid, 0);
        chk("t3_stall_in_ready", in_ready, 0);
        step();
        fwd_idle();
        mem_wb_rd = 4; mem_wb_reg_write = 1'b1; mem_wb_result = 32'hDEAD;
        #2;
        chk("t3_release_valid", out_valid, 1);
        chk("t3_release_srca", SrcA, 32'hDEAD);
        chk("t3_release_srcb", SrcB, 8);
        step();
        fwd_idle();
        #2;
        chk("t3_after_issue_valid", out_valid, 0);
        step();

        // Back-to-back stream of four
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            if (i < 4) begin
                in_valid = 1'b1; id_pc = 32'h100 + 4 * i; id_reg_write = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #2;
            if (i > 0) begin
                chk($sformatf("t4_issue%0d_valid", i), out_valid, 1);
                chk($sformatf("t4_issue%0d_pc", i), ex_pc, 32'h100 + 4 * (i - 1));
            end
            if (i < 4) chk($sformatf("t4_in_ready%0d", i), in_ready, 1);
            step();
        end
        #2;
        chk("t4_drained_valid", out_valid, 0);
        step();

        // Backpressure: outputs hold, offered instruction waits
        load(32'h200, 7, 8, 9, 11, 22, 33, 4'b0100, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; id_pc = 32'h300; out_ready = 1'b0;
            #2;
            chk($sformatf("t4_stall%0d_valid", i), out_valid, 1);
            chk($sformatf("t4_stall%0d_pc", i), ex_pc, 32'h200);
            chk($sformatf("t4_stall%0d_srca", i), SrcA, 11);
            chk($sformatf("t4_stall%0d_in_ready", i), in_ready, 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #2;
        chk("t4_release_pc", ex_pc, 32'h200);
        chk("t4_release_valid", out_valid, 1);
        step();
        #2;
        chk("t4_offer_dropped", out_valid, 0);
        step();

        // Operand refresh survives producer retirement
        load(32'h600, 1, 6, 0, 3, 1, 4, 4'b0101, 1, 0, 0, 1, 0);
        mem_wb_rd = 6; mem_wb_reg_write = 1'b1; mem_wb_result = 32'h1234;
        #2;
        chk("t5_fwd_store", ex_store_data, 32'h1234);
        step();
        fwd_idle();
        out_ready = 1'b1;
        #2;
        chk("t5_refresh_valid", out_valid, 1);
        chk("t5_refresh_store", ex_store_data, 32'h1234);
        step();
        out_ready = 1'b0;

        // Flush beats a simultaneous issue and accept
        load(32'h500, 1, 2, 3, 5, 7, 0, 4'b0101, 0, 1, 1, 1, 1);
        in_valid = 1'b1; id_pc = 32'h999; id_reg_write = 1'b1; out_ready = 1'b1; flush = 1'b1;
        #2;
        chk("t6_pre_flush_valid", out_valid, 1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #2;
        chk("t6_valid", out_valid, 0);
        chk("t6_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 4'b0000);
        chk("t6_in_ready", in_ready, 1);
        step();
        #2;
        chk("t6_dropped", out_valid, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
